// File: rtl/pcmplay_multitimer_pkg.sv
// pcmplay_multitimer_pkg: shared register offsets, bit indices and the
// CONTROL payload struct for the multi-channel interval timer.
package pcmplay_multitimer_pkg;

  // Per-channel register offsets within a block.
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  // Global block register offsets.
  localparam logic [1:0] GREG_IRQSTAT  = 2'd0;
  localparam logic [1:0] GREG_PRESCALE = 2'd1;
  localparam logic [1:0] GREG_GSTART   = 2'd2;

  // STATUS bit positions.
  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

  // CONTROL bit positions.
  localparam int unsigned CTL_ITO   = 0;
  localparam int unsigned CTL_CONT  = 1;
  localparam int unsigned CTL_START = 2;
  localparam int unsigned CTL_STOP  = 3;
  localparam int unsigned CTL_PRE   = 4;

  // Stored (non-pulse) CONTROL fields.
  typedef struct packed {
    logic pre;
    logic cont;
    logic ito;
  } ctrl_t;

endpackage

// File: rtl/pcmplay_timer_ch.sv
// pcmplay_timer_ch: one timer channel -- down-counter, RUN/TO flags,
// zero edge detect and (with PCMPLAY_MULTITIMER_SNAPSHOT_EN) a COUNT snapshot.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   tick_i                shared prescaler tick
//   ctrl_we_i/ctrl_wdata_i CONTROL write strobe and stored fields
//   start_i, stop_i       run start/stop pulses (start wins)
//   period_we_i/_wdata_i  PERIOD write (forces reload next cycle)
//   count_we_i            COUNT write (latches snapshot when enabled)
//   to_clr_i              clear TO
//   ctrl_o, run_o, to_o, period_o, count_o  register read values
module pcmplay_timer_ch
  import pcmplay_multitimer_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 24999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             ctrl_we_i,
  input  ctrl_t            ctrl_wdata_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             period_we_i,
  input  logic [CNT_W-1:0] period_wdata_i,
  input  logic             count_we_i,
  input  logic             to_clr_i,
  output ctrl_t            ctrl_o,
  output logic             run_o,
  output logic             to_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] count_o
);

  ctrl_t            ctrl_q, ctrl_d;
  logic             run_q, run_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;
  logic             force_reload_q, force_reload_d;
  logic             en, zero, evt;

  // Next-state for counter, RUN and TO.
  always_comb begin
    ctrl_d         = ctrl_q;
    run_d          = run_q;
    to_d           = to_q;
    period_d       = period_q;
    count_d        = count_q;
    force_reload_d = period_we_i;

    en   = run_q & (ctrl_q.pre ? tick_i : 1'b1);
    zero = (count_q == '0);
    // Timeout is the rising edge of zero, so a counter parked at 0 fires once.
    evt    = zero & ~zero_q;
    zero_d = zero;

    if (ctrl_we_i)   ctrl_d   = ctrl_wdata_i;
    if (period_we_i) period_d = period_wdata_i;

    if (force_reload_q)  count_d = period_q;
    else if (en)         count_d = zero ? period_q : count_q - CNT_W'(1);

    if (start_i)
      run_d = 1'b1;
    else if (stop_i | force_reload_q | (zero & ~ctrl_q.cont & en))
      run_d = 1'b0;

    // Set beats clear so no event is lost.
    if (evt)           to_d = 1'b1;
    else if (to_clr_i) to_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q         <= '0;
      run_q          <= 1'b0;
      to_q           <= 1'b0;
      period_q       <= CNT_W'(DEFAULT_PERIOD);
      count_q        <= CNT_W'(DEFAULT_PERIOD);
      zero_q         <= 1'b0;
      force_reload_q <= 1'b0;
    end else begin
      ctrl_q         <= ctrl_d;
      run_q          <= run_d;
      to_q           <= to_d;
      period_q       <= period_d;
      count_q        <= count_d;
      zero_q         <= zero_d;
      force_reload_q <= force_reload_d;
    end
  end

`ifdef PCMPLAY_MULTITIMER_SNAPSHOT_EN
  logic [CNT_W-1:0] snap_q, snap_d;

  // Snapshot of the live counter, captured by any COUNT write.
  always_comb begin
    snap_d = snap_q;
    if (count_we_i) snap_d = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) snap_q <= '0;
    else          snap_q <= snap_d;
  end

  assign count_o = snap_q;
`else
  logic unused_count_we;
  assign unused_count_we = count_we_i;
  assign count_o         = count_q;
`endif

  assign ctrl_o   = ctrl_q;
  assign run_o    = run_q;
  assign to_o     = to_q;
  assign period_o = period_q;

endmodule

// File: rtl/pcmplay_multitimer.sv
// pcmplay_multitimer: NUM_CH interval timers on an Avalon-MM slave with a
// shared prescaler, global start and per-channel/combined interrupts.
// Optional COUNT snapshot registers: define PCMPLAY_MULTITIMER_SNAPSHOT_EN.
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   address[ADDR_W-1:0]                 {block, reg} word address
//   chipselect, write_n, writedata[31:0] slave write interface
//   readdata[31:0]                      registered read data (1 cycle)
//   irq                                 OR of irq_vec
//   irq_vec[NUM_CH-1:0]                 per-channel TO & ITO
module pcmplay_multitimer
  import pcmplay_multitimer_pkg::*;
#(
  parameter  int unsigned NUM_CH         = 4,
  parameter  int unsigned CNT_W          = 32,
  parameter  int unsigned DEFAULT_PERIOD = 24999,
  parameter  int unsigned PRESCALE_W     = 16,
  localparam int unsigned ADDR_W         = $clog2(NUM_CH + 1) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int unsigned BLK_W = ADDR_W - 2;

  logic [BLK_W-1:0] blk;
  logic [1:0]       rsel;
  logic             wr, glob_sel;
  logic             irqstat_we, gstart_we, prescale_we;

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  pre_reload_q, pre_reload_d;
  logic                  tick;

  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic [NUM_CH-1:0] irq_vec_q, irq_vec_d;

  ctrl_t             ch_ctrl   [NUM_CH];
  logic [CNT_W-1:0]  ch_period [NUM_CH];
  logic [CNT_W-1:0]  ch_count  [NUM_CH];
  logic [NUM_CH-1:0] ch_to, ch_run, ito_vec;

  // Address decode.
  assign blk         = address[ADDR_W-1:2];
  assign rsel        = address[1:0];
  assign wr          = chipselect & ~write_n;
  assign glob_sel    = (blk == BLK_W'(NUM_CH));
  assign irqstat_we  = wr & glob_sel & (rsel == GREG_IRQSTAT);
  assign prescale_we = wr & glob_sel & (rsel == GREG_PRESCALE);
  assign gstart_we   = wr & glob_sel & (rsel == GREG_GSTART);

  // Prescaler: tick on zero, reload on tick or one cycle after a PRESCALE write.
  always_comb begin
    prescale_d   = prescale_q;
    pre_reload_d = prescale_we;
    tick         = (pre_cnt_q == '0);
    if (prescale_we) prescale_d = writedata[PRESCALE_W-1:0];
    if (pre_reload_q | tick) pre_cnt_d = prescale_q;
    else                     pre_cnt_d = pre_cnt_q - PRESCALE_W'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic  sel, ctrl_we;
    ctrl_t ctrl_wdata;

    assign sel        = wr & (blk == BLK_W'(c));
    assign ctrl_we    = sel & (rsel == REG_CONTROL);
    assign ctrl_wdata = '{pre: writedata[CTL_PRE], cont: writedata[CTL_CONT],
                          ito: writedata[CTL_ITO]};
    assign ito_vec[c] = ch_ctrl[c].ito;

    pcmplay_timer_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk            (clk),
      .reset_n        (reset_n),
      .tick_i         (tick),
      .ctrl_we_i      (ctrl_we),
      .ctrl_wdata_i   (ctrl_wdata),
      .start_i        ((ctrl_we & writedata[CTL_START]) | (gstart_we & writedata[c])),
      .stop_i         (ctrl_we & writedata[CTL_STOP]),
      .period_we_i    (sel & (rsel == REG_PERIOD)),
      .period_wdata_i (writedata[CNT_W-1:0]),
      .count_we_i     (sel & (rsel == REG_COUNT)),
      .to_clr_i       ((sel & (rsel == REG_STATUS) & writedata[ST_TO]) |
                       (irqstat_we & writedata[c])),
      .ctrl_o         (ch_ctrl[c]),
      .run_o          (ch_run[c]),
      .to_o           (ch_to[c]),
      .period_o       (ch_period[c]),
      .count_o        (ch_count[c])
    );
  end

  // Read mux; unmapped blocks and registers return 0.
  always_comb begin
    readdata_d = '0;
    if (glob_sel) begin
      case (rsel)
        GREG_IRQSTAT:  readdata_d = 32'(ch_to);
        GREG_PRESCALE: readdata_d = 32'(prescale_q);
        default:       readdata_d = '0;
      endcase
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (blk == BLK_W'(c)) begin
          case (rsel)
            REG_STATUS: begin
              readdata_d[ST_TO]  = ch_to[c];
              readdata_d[ST_RUN] = ch_run[c];
            end
            REG_CONTROL: begin
              readdata_d[CTL_ITO]  = ch_ctrl[c].ito;
              readdata_d[CTL_CONT] = ch_ctrl[c].cont;
              readdata_d[CTL_PRE]  = ch_ctrl[c].pre;
            end
            REG_PERIOD: readdata_d = 32'(ch_period[c]);
            default:    readdata_d = 32'(ch_count[c]);
          endcase
        end
      end
    end
  end

  // Interrupts.
  always_comb begin
    irq_vec_d = ch_to & ito_vec;
    irq_d     = |irq_vec_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q   <= '0;
      pre_cnt_q    <= '0;
      pre_reload_q <= 1'b0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
      irq_vec_q    <= '0;
    end else begin
      prescale_q   <= prescale_d;
      pre_cnt_q    <= pre_cnt_d;
      pre_reload_q <= pre_reload_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
      irq_vec_q    <= irq_vec_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign irq_vec  = irq_vec_q;

endmodule

// File: tb/tb_pcmplay_multitimer.sv
// tb_pcmplay_multitimer: self-checking bench for pcmplay_multitimer.
// Register reads go through a scoreboard queue; register access basics are a
// vector table, timer behaviour is covered by directed sequences.
module tb_pcmplay_multitimer;
  import pcmplay_multitimer_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned GBLK   = NUM_CH;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic [ADDR_W-1:0] address    = '0;
  logic              chipselect = 1'b0;
  logic              write_n    = 1'b1;
  logic [31:0]       writedata  = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pcmplay_multitimer #(
    .NUM_CH(4), .CNT_W(32), .DEFAULT_PERIOD(24999), .PRESCALE_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read scoreboard: expectation queued at issue, compared when readdata is valid.
  typedef struct { logic [31:0] exp; string name; } rd_exp_t;
  rd_exp_t sb_q[$];
  rd_exp_t mon_e;
  logic    rd_vld;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) rd_vld <= 1'b0;
    else          rd_vld <= chipselect & write_n;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, readdata, mon_e.exp);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] ra(input int unsigned blk, input logic [1:0] r);
    return {3'(blk), r};
  endfunction

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    sb_q.push_back('{exp: exp, name: name});
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  // Wait (bounded) for irq_vec[idx] to be high; t = cycle count at detection.
  task automatic wait_irq(input int unsigned idx, input int budget, input string name, output int t);
    bit seen;
    seen = 1'b0;
    t    = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (irq_vec[idx]) begin seen = 1'b1; t = cyc; end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: got no irq_vec[%0d] rise expected one within %0d clocks", name, idx, budget);
    end
  endtask

  typedef struct { logic is_wr; logic [ADDR_W-1:0] addr; logic [31:0] data; string name; } vec_t;
  vec_t vecs[$];

  function automatic void vw(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    vecs.push_back('{is_wr: 1'b1, addr: a, data: d, name: "wr"});
  endfunction
  function automatic void vr(input logic [ADDR_W-1:0] a, input logic [31:0] e, input string n);
    vecs.push_back('{is_wr: 1'b0, addr: a, data: e, name: n});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    int t1, t2;
    logic [31:0] exp_snap;

    // Register access table.
    vr(ra(0, REG_PERIOD), 32'd24999, "rst_period");
    vr(ra(0, REG_STATUS), 32'd0, "rst_status");
    vr(ra(GBLK, GREG_PRESCALE), 32'd0, "rst_prescale");
    vr(ra(0, REG_CONTROL), 32'd0, "rst_control");
`ifdef PCMPLAY_MULTITIMER_SNAPSHOT_EN
    vr(ra(3, REG_COUNT), 32'd0, "rst_count");
`else
    vr(ra(3, REG_COUNT), 32'd24999, "rst_count");
`endif
    vr(ra(GBLK, GREG_IRQSTAT), 32'd0, "rst_irqstat");
    vr(ra(GBLK, 2'd3), 32'd0, "greg3_zero");
    vw(ra(3, REG_CONTROL), 32'h1B);
    vr(ra(3, REG_CONTROL), 32'h13, "ctrl_pulse_bits_zero");
    vw(ra(3, REG_CONTROL), 32'h00);
    vr(ra(3, REG_CONTROL), 32'h00, "ctrl_cleared");
    vr(ra(3, REG_STATUS), 32'h0, "stop_only_no_run");
    vw(ra(3, REG_PERIOD), 32'hDEADBEEF);
    vr(ra(3, REG_PERIOD), 32'hDEADBEEF, "period_full_width");
    vw(ra(GBLK, GREG_PRESCALE), 32'h0001_2345);
    vr(ra(GBLK, GREG_PRESCALE), 32'h0000_2345, "prescale_width");
    vw(ra(GBLK, GREG_PRESCALE), 32'h0);
    vw(ra(5, REG_PERIOD), 32'hFFFF_FFFF);
    vr(ra(5, REG_PERIOD), 32'h0, "unmapped_blk5");
    vr(ra(7, REG_STATUS), 32'h0, "unmapped_blk7");

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_vec", 32'(irq_vec), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].data);
      else               bus_read(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // One-shot ch1, P=5: irq_vec[1] rises 7 clocks after the START edge.
    bus_write(ra(1, REG_PERIOD), 32'd5);
    bus_write(ra(1, REG_CONTROL), 32'h05);
    repeat (6) @(negedge clk);
    check("oneshot_irq_early", 32'(irq_vec[1]), 32'd0);
    @(negedge clk);
    check("oneshot_irq_vec", 32'(irq_vec), 32'h2);
    check("oneshot_irq", 32'(irq), 32'd1);
    bus_read(ra(1, REG_STATUS), 32'h1, "oneshot_status");
    bus_write(ra(1, REG_STATUS), 32'h1);
    @(negedge clk);
    check("status_clr_irq", 32'(irq), 32'd0);

    // Clear written on the exact event cycle: TO must survive.
    bus_write(ra(1, REG_CONTROL), 32'h05);
    repeat (4) @(negedge clk);
    bus_write(ra(1, REG_STATUS), 32'h1);
    @(negedge clk);
    check("collide_irq_vec1", 32'(irq_vec[1]), 32'd1);
    bus_read(ra(1, REG_STATUS), 32'h1, "collide_status");
    bus_write(ra(1, REG_STATUS), 32'h1);

    // ch3 one-shot leaves TO set so IRQSTAT selectivity can be seen.
    bus_write(ra(3, REG_PERIOD), 32'd3);
    bus_write(ra(3, REG_CONTROL), 32'h05);
    repeat (8) @(negedge clk);
    check("ch3_irq", 32'(irq_vec[3]), 32'd1);

    // Continuous + prescale: PRESCALE=3, P=2 -> one event per 12 clocks.
    bus_write(ra(GBLK, GREG_PRESCALE), 32'd3);
    bus_write(ra(0, REG_PERIOD), 32'd2);
    bus_write(ra(0, REG_CONTROL), 32'h17);
    wait_irq(0, 60, "cont_first", t1);
    bus_write(ra(GBLK, GREG_IRQSTAT), 32'h1);
    @(negedge clk);
    check("irqstat_clr_ch0", 32'(irq_vec), 32'h8);
    bus_read(ra(GBLK, GREG_IRQSTAT), 32'h8, "irqstat_only_ch3");
    wait_irq(0, 30, "cont_second", t2);
    check("cont_interval", 32'(t2 - t1), 32'd12);

    // Global start: ch0 and ch2 with P=4 raise their irqs on the same cycle.
    bus_write(ra(0, REG_CONTROL), 32'h09);
    bus_write(ra(2, REG_CONTROL), 32'h01);
    bus_write(ra(GBLK, GREG_PRESCALE), 32'd0);
    bus_write(ra(0, REG_PERIOD), 32'd4);
    bus_write(ra(2, REG_PERIOD), 32'd4);
    bus_write(ra(GBLK, GREG_IRQSTAT), 32'hF);
    @(negedge clk);
    check("gstart_pre_clear", 32'(irq_vec), 32'h0);
    bus_write(ra(GBLK, GREG_GSTART), 32'h5);
    repeat (5) @(negedge clk);
    check("gstart_early", 32'(irq_vec), 32'h0);
    @(negedge clk);
    check("gstart_irq_vec", 32'(irq_vec), 32'h5);
    bus_read(ra(1, REG_STATUS), 32'h0, "gstart_ch1_idle");
    bus_write(ra(GBLK, GREG_IRQSTAT), 32'hF);

    // START|STOP together starts; PERIOD write while running stops and reloads.
    bus_write(ra(2, REG_PERIOD), 32'd200);
    bus_write(ra(2, REG_CONTROL), 32'h0C);
    bus_read(ra(2, REG_STATUS), 32'h2, "start_stop_run");
    bus_write(ra(2, REG_PERIOD), 32'h1234);
    bus_read(ra(2, REG_STATUS), 32'h0, "period_wr_stops");
    bus_write(ra(2, REG_COUNT), 32'h0);
    bus_read(ra(2, REG_COUNT), 32'h1234, "period_wr_reload");

    // COUNT snapshot vs live counter.
    bus_write(ra(3, REG_PERIOD), 32'd100);
    bus_write(ra(3, REG_CONTROL), 32'h04);
    bus_write(ra(3, REG_COUNT), 32'h0);
    repeat (10) @(negedge clk);
`ifdef PCMPLAY_MULTITIMER_SNAPSHOT_EN
    exp_snap = 32'd99;
`else
    exp_snap = 32'd87;
`endif
    bus_read(ra(3, REG_COUNT), exp_snap, "count_read");

    // Reset mid-count: everything back to reset values, no event.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", readdata, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(ra(3, REG_STATUS), 32'h0, "midrst_status");
    bus_read(ra(3, REG_PERIOD), 32'd24999, "midrst_period");
    repeat (4) @(negedge clk);
    check("midrst_no_irq", 32'(irq_vec), 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
